// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EX: one quotient bit per cycle,
// holds EX via div_stallE while running and keeps {remainder, quotient} stable in DONE.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               div_validE,
    input  logic               div_signE,
    input  logic [WIDTH-1:0]   src_aE,
    input  logic [WIDTH-1:0]   src_bE,
    input  logic               pipe_stall,
    input  logic               flush,
    output logic               div_stallE,
    output logic [2*WIDTH-1:0] div_result,
    output logic               div_ready,
    output logic [1:0]         dbgState
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      counter;
    logic [WIDTH-1:0]   dividendReg;
    logic [WIDTH-1:0]   divisorReg;
    logic [WIDTH-1:0]   remReg;
    logic               signQ;
    logic               signR;
    logic [2*WIDTH-1:0] resultReg;

    logic               aNeg;
    logic               bNeg;
    logic [WIDTH-1:0]   aMag;
    logic [WIDTH-1:0]   bMag;
    logic [WIDTH:0]     remShift;
    logic               fits;
    logic [WIDTH-1:0]   remNext;
    logic [WIDTH-1:0]   quotNext;
    logic [WIDTH-1:0]   quotFixed;
    logic [WIDTH-1:0]   remFixed;

    // Magnitudes are modulo 2^WIDTH, so the most negative value maps onto itself as an unsigned 2^(WIDTH-1).
    always_comb begin
        aNeg = div_signE & src_aE[WIDTH-1];
        bNeg = div_signE & src_bE[WIDTH-1];
        aMag = aNeg ? -src_aE : src_aE;
        bMag = bNeg ? -src_bE : src_bE;
    end

    // The dividend register shifts left each step; freed LSBs collect the quotient bits.
    always_comb begin
        remShift  = {remReg, dividendReg[WIDTH-1]};
        fits      = (remShift >= {1'b0, divisorReg});
        remNext   = fits ? WIDTH'(remShift - {1'b0, divisorReg}) : remShift[WIDTH-1:0];
        quotNext  = {dividendReg[WIDTH-2:0], fits};
        quotFixed = signQ ? -quotNext : quotNext;
        remFixed  = signR ? -remNext : remNext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            counter     <= '0;
            dividendReg <= '0;
            divisorReg  <= '0;
            remReg      <= '0;
            signQ       <= 1'b0;
            signR       <= 1'b0;
            resultReg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_validE && !flush) begin
                        dividendReg <= aMag;
                        divisorReg  <= bMag;
                        signQ       <= aNeg ^ bNeg;
                        signR       <= aNeg;
                        remReg      <= '0;
                        counter     <= '0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush || !div_validE) begin
                        state <= IDLE;
                    end else begin
                        remReg      <= remNext;
                        dividendReg <= quotNext;
                        counter     <= counter + CW'(1);
                        if (counter == LAST_STEP) begin
                            resultReg <= {remFixed, quotFixed};
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (flush || !pipe_stall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign div_stallE = div_validE & (state != DONE) & ~flush;
    assign div_ready  = (state == DONE);
    assign div_result = resultReg;
    assign dbgState   = state;

endmodule
